// File: rtl/pwm_pkg.sv
// Shared constants, control-register layout and the slew helper for the
// multi-channel ramped PWM driver.
package pwm_pkg;

  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam int         CTRL_EN_BIT  = 0;
  localparam int         CTRL_INV_BIT = 1;
  localparam int         DUTY_W       = 8;
  localparam int         CNT_W        = 8;

  typedef struct packed {
    logic enable;
    logic invert;
  } ctrl_t;

  // Next active duty: move from cur toward tgt by at most step, never past tgt.
  // Sums are formed in 9 bits so neither direction can wrap.
  function automatic logic [DUTY_W-1:0] ramp_next(input logic [DUTY_W-1:0] cur,
                                                  input logic [DUTY_W-1:0] tgt,
                                                  input logic [DUTY_W:0]   step);
    logic [DUTY_W:0] w_sum;
    // NOTE: the result gets a default before any branch, so no path through
    // this logic leaves it unassigned (which would infer a latch).
    ramp_next = cur;
    w_sum     = '0;
    if (step == '0) begin
      ramp_next = tgt;
    end else if (tgt > cur) begin
      w_sum     = {1'b0, cur} + step;
      ramp_next = (w_sum >= {1'b0, tgt}) ? tgt : w_sum[DUTY_W-1:0];
    end else if (tgt < cur) begin
      w_sum     = {1'b0, tgt} + step;
      ramp_next = ({1'b0, cur} <= w_sum) ? tgt : cur - step[DUTY_W-1:0];
    end
  endfunction

endpackage

// File: rtl/pwm_ramp_ch.sv
// One PWM channel: holds the active duty, slews it toward the target once per
// period, and compares it against the shared period counter.
module pwm_ramp_ch
  import pwm_pkg::*;
#(
  parameter int RAMP_STEP = 0
) (
  input  logic              clk50M,
  input  logic              rst,
  input  logic [DUTY_W-1:0] i_target,
  input  logic              i_boundary,
  input  logic [CNT_W-1:0]  i_cnt,
  output logic              o_raw
);

  localparam logic [DUTY_W:0] STEP9 = (DUTY_W+1)'(RAMP_STEP);

  logic [DUTY_W-1:0] r_active;

  // Active duty moves only at the period boundary so a period never changes width mid-way.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      r_active <= '0;
    end else if (i_boundary) begin
      r_active <= ramp_next(r_active, i_target, STEP9);
    end
  end

  assign o_raw = (r_active > i_cnt);

endmodule

// File: rtl/pwm_multi_ramp.sv
// N_CH-channel PWM driver fed by 16-bit address/data packets. Holds the
// prescaler, period counter, packet decoder and control register; each
// channel's duty handling lives in pwm_ramp_ch.
module pwm_multi_ramp
  import pwm_pkg::*;
#(
  parameter int N_CH      = 3,
  parameter int PRESCALE  = 1,
  parameter int RAMP_STEP = 0
) (
  input  logic            clk50M,
  input  logic            rst,
  input  logic [15:0]     byte_data_received,
  input  logic            byte_received,
  output logic [N_CH-1:0] pwm_out,
  output logic            period_start
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0]       r_pre;
  logic [CNT_W-1:0]  r_cnt;
  ctrl_t             r_ctrl;
  logic              w_tick;
  logic              w_boundary;
  logic [7:0]        w_addr;
  logic [7:0]        w_data;
  logic [N_CH-1:0]   w_raw;
  logic [N_CH-1:0]   w_inv_mask;

  assign w_addr     = byte_data_received[15:8];
  assign w_data     = byte_data_received[7:0];
  assign w_tick     = (r_pre == PRE_LAST);
  assign w_boundary = w_tick && (r_cnt == '1);
  assign w_inv_mask = {N_CH{r_ctrl.invert}};

  // Prescaler: one tick every PRESCALE clocks.
  always_ff @(posedge clk50M or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (rst) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 16'd1;
    end
  end

  // Period counter advances on each tick and wraps naturally at 255.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Control register: enable and invert take effect immediately, not at the boundary.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      r_ctrl.enable <= 1'b1;
      r_ctrl.invert <= 1'b0;
    end else if (byte_received && (w_addr == ADDR_CTRL)) begin
      r_ctrl.enable <= w_data[CTRL_EN_BIT];
      r_ctrl.invert <= w_data[CTRL_INV_BIT];
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    localparam logic [7:0] CH_ADDR = 8'(k + 1);

    logic [DUTY_W-1:0] r_target;

    // Target (shadow) duty for this channel, written straight from the packet bus.
    always_ff @(posedge clk50M or posedge rst) begin
      // NOTE: duty registers are reset explicitly so the first period after
      // reset is guaranteed to be fully off.
      if (rst) begin
        r_target <= '0;
      end else if (byte_received && (w_addr == CH_ADDR)) begin
        r_target <= w_data;
      end
    end

    pwm_ramp_ch #(
      .RAMP_STEP (RAMP_STEP)
    ) u_ch (
      .clk50M     (clk50M),
      .rst        (rst),
      .i_target   (r_target),
      .i_boundary (w_boundary),
      .i_cnt      (r_cnt),
      .o_raw      (w_raw[k])
    );
  end

  // Registered outputs: polarity/enable applied here so the pins never glitch.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= r_ctrl.enable ? (w_raw ^ w_inv_mask) : w_inv_mask;
      period_start <= w_boundary;
    end
  end

endmodule
